// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bundle: requester handshake plus broadcast outputs.
// The requesters and the testbench use the master side. The arbiter uses the slave side.
interface cdb_arbiter_if #(
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 4,
   parameter int NREQ    = 4
);
   logic [NREQ-1:0]         reqValid;
   logic [NREQ*LABEL_W-1:0] reqLabel;
   logic [NREQ*DATA_W-1:0]  reqData;
   logic [NREQ-1:0]         reqReady;
   logic                    BCEN;
   logic [LABEL_W-1:0]      BClabel;
   logic [DATA_W-1:0]       BCdata;
   logic [NREQ-1:0]         pending;

   modport master (
      output reqValid, reqLabel, reqData,
      input  reqReady, BCEN, BClabel, BCdata, pending
   );

   modport slave (
      input  reqValid, reqLabel, reqData,
      output reqReady, BCEN, BClabel, BCdata, pending
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter.
// Each requester (alu, mul, div, load) owns a one-entry holding buffer.
// At most one full buffer is broadcast per cycle, and every broadcast comes from a register.
module cdb_arbiter #(
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 4,
   parameter int NREQ    = 4
) (
   input logic          clk,
   input logic          nRST,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    full_q, full_d;
   logic [LABEL_W-1:0] label_q [NREQ];
   logic [DATA_W-1:0]  data_q  [NREQ];
   logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
   logic               bcen_q;
   logic [LABEL_W-1:0] bcLabel_q;
   logic [DATA_W-1:0]  bcData_q;

   logic [NREQ-1:0]    grant;
   logic               anyGrant;
   logic [PTR_W-1:0]   grantIdx;
   logic [PTR_W-1:0]   cand;
   logic [NREQ-1:0]    readyVec;
   logic [NREQ-1:0]    fill;

   // Search the full buffers from rrPtr upward, wrapping to 0. The first full buffer found wins the bus.
   always_comb begin
      grant    = '0;
      anyGrant = 1'b0;
      grantIdx = '0;
      cand     = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PTR_W'((int'(rrPtr_q) + k) % NREQ);
         if (!anyGrant && full_q[cand]) begin
            grant[cand] = 1'b1;
            anyGrant    = 1'b1;
            grantIdx    = cand;
         end
      end
   end

   // A buffer can take a new entry when it is empty, or when it is being drained on this edge.
   // A transfer with label 0 is acknowledged but never occupies the buffer.
   always_comb begin
      readyVec = ~full_q | grant;
      fill     = '0;
      for (int i = 0; i < NREQ; i++) begin
         fill[i] = bus.reqValid[i] && readyVec[i] &&
                   (bus.reqLabel[i*LABEL_W +: LABEL_W] != '0);
      end
      full_d  = fill | (full_q & ~grant);
      rrPtr_d = anyGrant ? PTR_W'((int'(grantIdx) + 1) % NREQ) : rrPtr_q;
   end

   // Holding buffers and the round-robin pointer. A refill arriving on the same edge as a grant overrides the drain.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         full_q  <= '0;
         rrPtr_q <= '0;
         for (int i = 0; i < NREQ; i++) begin
            label_q[i] <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         full_q  <= full_d;
         rrPtr_q <= rrPtr_d;
         for (int i = 0; i < NREQ; i++) begin
            if (fill[i]) begin
               label_q[i] <= bus.reqLabel[i*LABEL_W +: LABEL_W];
               data_q[i]  <= bus.reqData[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Broadcast register. The granted entry goes out on the next cycle. With no grant, label and data hold their values and valid drops.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         bcen_q    <= 1'b0;
         bcLabel_q <= '0;
         bcData_q  <= '0;
      end else if (anyGrant) begin
         bcen_q    <= 1'b1;
         bcLabel_q <= label_q[grantIdx];
         bcData_q  <= data_q[grantIdx];
      end else begin
         bcen_q    <= 1'b0;
      end
   end

   assign bus.reqReady = readyVec;
   assign bus.pending  = full_q;
   assign bus.BCEN     = bcen_q;
   assign bus.BClabel  = bcLabel_q;
   assign bus.BCdata   = bcData_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter.
// Every expected broadcast goes into a queue when its stimulus is driven.
// A negedge monitor pops the queue each time BCEN is seen and compares the entry.
module tb_cdb_arbiter;
   localparam int DATA_W  = 32;
   localparam int LABEL_W = 4;
   localparam int NREQ    = 4;

   logic clk;
   logic nRST;
   int   compared   = 0;
   int   mismatched = 0;

   logic [LABEL_W+DATA_W-1:0] sbQ [$];

   cdb_arbiter_if #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .NREQ(NREQ)) bus ();

   cdb_arbiter #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .NREQ(NREQ)) dut (
      .clk  (clk),
      .nRST (nRST),
      .bus  (bus)
   );

   // Free-running clock with a period of 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one requester slot.
   task automatic applyStimulus(input int idx, input logic v,
                                input logic [LABEL_W-1:0] lab,
                                input logic [DATA_W-1:0] dat);
      bus.reqValid[idx]                    = v;
      bus.reqLabel[idx*LABEL_W +: LABEL_W] = lab;
      bus.reqData[idx*DATA_W +: DATA_W]    = dat;
   endtask

   // Compare one observed value against the value the bench expects.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor. Every broadcast must match the oldest expected entry.
   always @(negedge clk) begin
      if (nRST && bus.BCEN) begin
         if (sbQ.size() == 0) begin
            compared++;
            assert (sbQ.size() != 0)
            else begin
               mismatched++;
               $error("[TB] FAIL sb_unexpected: observed broadcast label %0h data %0h, expected none",
                      bus.BClabel, bus.BCdata);
            end
         end else begin
            checkOutput("sb_bcast", {28'd0, bus.BClabel, bus.BCdata}, {28'd0, sbQ.pop_front()});
         end
      end
   end

   initial begin : stim
      logic [LABEL_W-1:0] cLab  [4];
      logic [NREQ-1:0]    cPend [4];
      cLab  = '{4'd1, 4'd5, 4'd9, 4'd13};
      cPend = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

      nRST = 1'b0;
      bus.reqValid = '0;
      bus.reqLabel = '0;
      bus.reqData  = '0;

      // Reset state.
      tick();
      tick();
      checkOutput("rst_bcen",    64'(bus.BCEN),     64'd0);
      checkOutput("rst_label",   64'(bus.BClabel),  64'd0);
      checkOutput("rst_data",    64'(bus.BCdata),   64'd0);
      checkOutput("rst_pending", 64'(bus.pending),  64'd0);
      checkOutput("rst_ready",   64'(bus.reqReady), 64'hF);
      nRST = 1'b1;

      // A single alu result appears on the bus two edges after it is driven.
      $display("[TB] single alu broadcast");
      applyStimulus(0, 1'b1, 4'd3, 32'h0000_00AA);
      sbQ.push_back({4'd3, 32'h0000_00AA});
      tick();
      applyStimulus(0, 1'b0, 4'd0, 32'd0);
      checkOutput("single_pend1", 64'(bus.pending), 64'b0001);
      checkOutput("single_lat",   64'(bus.BCEN),    64'd0);
      tick();
      checkOutput("single_bcen",  64'(bus.BCEN),    64'd1);
      checkOutput("single_label", 64'(bus.BClabel), 64'd3);
      checkOutput("single_data",  64'(bus.BCdata),  64'hAA);
      checkOutput("single_pend2", 64'(bus.pending), 64'd0);
      tick();
      checkOutput("single_drop",  64'(bus.BCEN),    64'd0);
      checkOutput("single_hold",  64'(bus.BClabel), 64'd3);

      // Nothing is captured while reset is held. Releasing reset also returns the pointer to 0.
      $display("[TB] capture blocked in reset");
      nRST = 1'b0;
      applyStimulus(3, 1'b1, 4'd5, 32'h55);
      tick();
      tick();
      checkOutput("rstcap_pend", 64'(bus.pending), 64'd0);
      applyStimulus(3, 1'b0, 4'd0, 32'd0);
      nRST = 1'b1;
      tick();
      checkOutput("rstcap_bcen", 64'(bus.BCEN), 64'd0);

      // All four requesters at once drain in index order, starting from 0.
      $display("[TB] four-way contention");
      for (int i = 0; i < NREQ; i++) begin
         applyStimulus(i, 1'b1, cLab[i], 32'h1000 + i);
         sbQ.push_back({cLab[i], 32'h1000 + i});
      end
      tick();
      bus.reqValid = '0;
      checkOutput("cont_pend0", 64'(bus.pending), 64'b1111);
      for (int k = 0; k < 4; k++) begin
         tick();
         checkOutput("cont_bcen",  64'(bus.BCEN),    64'd1);
         checkOutput("cont_label", 64'(bus.BClabel), 64'(cLab[k]));
         checkOutput("cont_pend",  64'(bus.pending), 64'(cPend[k]));
      end
      tick();
      checkOutput("cont_idle", 64'(bus.BCEN), 64'd0);

      // Round robin: granting mul moves rrPtr to 2. Buffers 0 and 3 fill on that same edge.
      $display("[TB] round-robin wrap");
      applyStimulus(1, 1'b1, 4'd2, 32'h22);
      sbQ.push_back({4'd2, 32'h22});
      tick();
      applyStimulus(1, 1'b0, 4'd0, 32'd0);
      applyStimulus(0, 1'b1, 4'd4, 32'h44);
      applyStimulus(3, 1'b1, 4'd11, 32'hBB);
      sbQ.push_back({4'd11, 32'hBB});
      sbQ.push_back({4'd4, 32'h44});
      tick();
      bus.reqValid = '0;
      checkOutput("rr_label1", 64'(bus.BClabel), 64'd2);
      checkOutput("rr_pend1",  64'(bus.pending), 64'b1001);
      tick();
      checkOutput("rr_label2", 64'(bus.BClabel), 64'd11);
      checkOutput("rr_pend2",  64'(bus.pending), 64'b0001);
      tick();
      checkOutput("rr_label3", 64'(bus.BClabel), 64'd4);
      checkOutput("rr_pend3",  64'(bus.pending), 64'd0);

      // Refill: mul streams 6 then 7 into its buffer while that buffer is being granted.
      $display("[TB] refill while granted");
      applyStimulus(1, 1'b1, 4'd6, 32'h66);
      sbQ.push_back({4'd6, 32'h66});
      tick();
      checkOutput("refill_ready1", 64'(bus.reqReady[1]), 64'd1);
      applyStimulus(1, 1'b1, 4'd7, 32'h77);
      sbQ.push_back({4'd7, 32'h77});
      tick();
      applyStimulus(1, 1'b0, 4'd0, 32'd0);
      checkOutput("refill_label1", 64'(bus.BClabel),    64'd6);
      checkOutput("refill_pend1",  64'(bus.pending[1]), 64'd1);
      tick();
      checkOutput("refill_bcen",   64'(bus.BCEN),       64'd1);
      checkOutput("refill_label2", 64'(bus.BClabel),    64'd7);
      checkOutput("refill_pend2",  64'(bus.pending[1]), 64'd0);
      tick();
      checkOutput("refill_idle",   64'(bus.BCEN),       64'd0);

      // A label-0 transfer is acknowledged and then dropped.
      $display("[TB] label zero discard");
      applyStimulus(2, 1'b1, 4'd0, 32'hDD);
      #1;
      checkOutput("lab0_ready", 64'(bus.reqReady[2]), 64'd1);
      tick();
      applyStimulus(2, 1'b0, 4'd0, 32'd0);
      checkOutput("lab0_pend", 64'(bus.pending), 64'd0);
      tick();
      checkOutput("lab0_bcen1", 64'(bus.BCEN), 64'd0);
      tick();
      checkOutput("lab0_bcen2", 64'(bus.BCEN), 64'd0);

      // Reset between edges throws away three buffered results.
      $display("[TB] reset mid-run");
      applyStimulus(0, 1'b1, 4'd8,  32'h88);
      applyStimulus(1, 1'b1, 4'd9,  32'h99);
      applyStimulus(2, 1'b1, 4'd10, 32'hA0);
      tick();
      bus.reqValid = '0;
      checkOutput("mid_pend_full", 64'(bus.pending), 64'b0111);
      #1;
      nRST = 1'b0;
      #1;
      checkOutput("mid_bcen",  64'(bus.BCEN),     64'd0);
      checkOutput("mid_label", 64'(bus.BClabel),  64'd0);
      checkOutput("mid_data",  64'(bus.BCdata),   64'd0);
      checkOutput("mid_pend",  64'(bus.pending),  64'd0);
      checkOutput("mid_ready", 64'(bus.reqReady), 64'hF);
      #1;
      nRST = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("post_bcen", 64'(bus.BCEN),    64'd0);
         checkOutput("post_pend", 64'(bus.pending), 64'd0);
      end

      checkOutput("sb_left", 64'(sbQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
